// File: rtl/error_sum_serial_transmitter.sv
// Snapshots per-output error sums on iDoneProcessing and streams them as a byte frame
// over a valid/ready handshake. Define ERROR_SUM_TX_CHECKSUM_EN to append an XOR checksum byte.
module error_sum_serial_transmitter #(
    parameter int         NUM_OUTPUTS = 8,
    parameter int         SUM_WIDTH   = 32,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic                                   iClock,
    input  logic                                   iReset_n,
    input  logic                                   iDoneProcessing,
    input  logic [NUM_OUTPUTS-1:0][SUM_WIDTH-1:0]  iErrorSums,
    input  logic                                   iTxReady,
    output logic [7:0]                             oTxByte,
    output logic                                   oTxValid,
    output logic                                   oDoneProcessingFeedback,
    output logic                                   oBusy
);

    localparam int BYTES_PER_SUM = SUM_WIDTH / 8;
    localparam int PAYLOAD_BYTES = NUM_OUTPUTS * BYTES_PER_SUM;
    localparam int SHADOW_W      = PAYLOAD_BYTES * 8;
    localparam int IDX_W         = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

`ifdef ERROR_SUM_TX_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, SEND_SYNC, SEND_PAYLOAD, SEND_CHECKSUM, ACK, RELEASE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, SEND_SYNC, SEND_PAYLOAD, ACK, RELEASE
    } state_t;
`endif

    state_t              state;
    state_t              next_state;
    logic [SHADOW_W-1:0] shadow;
    logic [IDX_W-1:0]    idx;
    logic                tx_fire;
    logic                capture;
    logic [7:0]          head_byte;
`ifdef ERROR_SUM_TX_CHECKSUM_EN
    logic [7:0]          checksum;
`endif

    // Shadow is stored with the next payload byte in the top 8 bits, so sending is a left shift.
    assign head_byte = shadow[SHADOW_W-1 -: 8];
    assign tx_fire   = oTxValid && iTxReady;
    assign capture   = (state == IDLE) && iDoneProcessing;
    assign oBusy     = (state != IDLE);

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state                   <= IDLE;
            shadow                  <= '0;
            idx                     <= '0;
            oDoneProcessingFeedback <= 1'b0;
`ifdef ERROR_SUM_TX_CHECKSUM_EN
            checksum                <= '0;
`endif
        end else begin
            state <= next_state;
            // Feedback is registered, so the pulse lands in the cycle after ACK.
            oDoneProcessingFeedback <= (state == ACK);
            if (capture) begin
                for (int i = 0; i < NUM_OUTPUTS; i++) begin
                    shadow[(NUM_OUTPUTS-1-i)*SUM_WIDTH +: SUM_WIDTH] <= iErrorSums[i];
                end
                idx <= '0;
`ifdef ERROR_SUM_TX_CHECKSUM_EN
                checksum <= '0;
`endif
            end
            if (state == SEND_SYNC && tx_fire) begin
                idx <= '0;
            end
            if (state == SEND_PAYLOAD && tx_fire) begin
                shadow <= {shadow[SHADOW_W-9:0], 8'h00};
                idx    <= idx + IDX_W'(1);
`ifdef ERROR_SUM_TX_CHECKSUM_EN
                checksum <= checksum ^ head_byte;
`endif
            end
        end
    end

    always_comb begin
        next_state = state;
        oTxValid   = 1'b0;
        oTxByte    = 8'h00;
        case (state)
            IDLE: begin
                if (iDoneProcessing) next_state = SEND_SYNC;
            end
            SEND_SYNC: begin
                oTxValid = 1'b1;
                oTxByte  = SYNC_BYTE;
                if (iTxReady) next_state = SEND_PAYLOAD;
            end
            SEND_PAYLOAD: begin
                oTxValid = 1'b1;
                oTxByte  = head_byte;
                if (iTxReady && idx == LAST_IDX) begin
`ifdef ERROR_SUM_TX_CHECKSUM_EN
                    next_state = SEND_CHECKSUM;
`else
                    next_state = ACK;
`endif
                end
            end
`ifdef ERROR_SUM_TX_CHECKSUM_EN
            SEND_CHECKSUM: begin
                oTxValid = 1'b1;
                oTxByte  = checksum;
                if (iTxReady) next_state = ACK;
            end
`endif
            ACK: begin
                next_state = RELEASE;
            end
            RELEASE: begin
                if (!iDoneProcessing) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_error_sum_serial_transmitter.sv
// Directed self-checking bench for error_sum_serial_transmitter (default 8 x 32-bit sums).
// Define ERROR_SUM_TX_CHECKSUM_EN to exercise the checksum build.
module tb_error_sum_serial_transmitter;

    localparam int NUM_OUTPUTS = 8;
    localparam int SUM_WIDTH   = 32;
`ifdef ERROR_SUM_TX_CHECKSUM_EN
    localparam int FRAME_LEN = 34;
    localparam int ACK_LAT   = 36;
`else
    localparam int FRAME_LEN = 33;
    localparam int ACK_LAT   = 35;
`endif

    typedef logic [NUM_OUTPUTS-1:0][SUM_WIDTH-1:0] sums_t;

    logic       iClock = 1'b0;
    logic       iReset_n = 1'b0;
    logic       iDoneProcessing = 1'b0;
    sums_t      iErrorSums = '0;
    logic       iTxReady = 1'b1;
    logic [7:0] oTxByte;
    logic       oTxValid;
    logic       oDoneProcessingFeedback;
    logic       oBusy;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         n_cyc = -1;
    int         first_valid_cyc = -1;
    int         last_xfer_cyc = -1;
    int         stall_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic [7:0] rx[$];
    int         acks[$];
    logic [7:0] exp_q[$];

    error_sum_serial_transmitter dut (
        .iClock                  (iClock),
        .iReset_n                (iReset_n),
        .iDoneProcessing         (iDoneProcessing),
        .iErrorSums              (iErrorSums),
        .iTxReady                (iTxReady),
        .oTxByte                 (oTxByte),
        .oTxValid                (oTxValid),
        .oDoneProcessingFeedback (oDoneProcessingFeedback),
        .oBusy                   (oBusy)
    );

    always #5 iClock = ~iClock;

    always @(posedge iClock) cyc++;

    // Passive monitor: samples mid-cycle, logs transfers, ack pulses and stall violations.
    always @(negedge iClock) begin
        if (iReset_n) begin
            if (iDoneProcessing && !oBusy) n_cyc = cyc;
            if (oTxValid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall && (!oTxValid || oTxByte !== prev_byte)) stall_err++;
            prev_stall = oTxValid && !iTxReady;
            prev_byte  = oTxByte;
            if (oTxValid && iTxReady) begin
                rx.push_back(oTxByte);
                last_xfer_cyc = cyc;
            end
            if (oDoneProcessingFeedback) acks.push_back(cyc);
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_mon();
        rx.delete();
        acks.delete();
        n_cyc = -1;
        first_valid_cyc = -1;
        last_xfer_cyc = -1;
        stall_err = 0;
    endtask

    task automatic next_cycle();
        @(posedge iClock);
        #2;
    endtask

    task automatic build_expected(input sums_t s);
        logic [7:0] x;
        x = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            for (int b = SUM_WIDTH/8 - 1; b >= 0; b--) begin
                exp_q.push_back(s[i][b*8 +: 8]);
                x ^= s[i][b*8 +: 8];
            end
        end
`ifdef ERROR_SUM_TX_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic pulse_done();
        iDoneProcessing = 1'b1;
        next_cycle();
        iDoneProcessing = 1'b0;
    endtask

    task automatic wait_ack(input int budget, input bit random_ready, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            next_cycle();
            if (random_ready) iTxReady = ($urandom_range(0, 9) < 3);
            if (acks.size() > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        iTxReady = 1'b1;
        repeat (3) next_cycle();
    endtask

    task automatic reset_dut();
        iReset_n = 1'b0;
        iDoneProcessing = 1'b0;
        iTxReady = 1'b1;
        repeat (2) next_cycle();
        iReset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        iReset_n = 1'b0;
        #1;
        checks++;
        if (oTxValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", oTxValid); end
        checks++;
        if (oTxByte !== 8'h00) begin errors++; $display("[TB] FAIL reset_byte got %h want 00", oTxByte); end
        checks++;
        if (oDoneProcessingFeedback !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got %b want 0", oDoneProcessingFeedback); end
        checks++;
        if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", oBusy); end
        reset_dut();
    endtask

    task automatic test_zero_frame();
        bit to;
        sums_t s;
        s = '0;
        iErrorSums = s;
        build_expected(s);
        clear_mon();
        pulse_done();
        wait_ack(200, 1'b0, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL zero_ack_timeout got timeout want ack"); end
        checks++;
        if (rx.size() != FRAME_LEN) begin errors++; $display("[TB] FAIL zero_len got %0d want %0d", rx.size(), FRAME_LEN); end
        for (int i = 0; i < FRAME_LEN && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL zero_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
        end
        checks++;
        if (first_valid_cyc != n_cyc + 1) begin errors++; $display("[TB] FAIL valid_latency got %0d want %0d", first_valid_cyc - n_cyc, 1); end
        checks++;
        if (acks.size() != 1) begin errors++; $display("[TB] FAIL zero_ack_count got %0d want 1", acks.size()); end
        else begin
            checks++;
            if (acks[0] != n_cyc + ACK_LAT) begin errors++; $display("[TB] FAIL ack_latency got %0d want %0d", acks[0] - n_cyc, ACK_LAT); end
        end
        checks++;
        if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL zero_idle_busy got %b want 0", oBusy); end
    endtask

    task automatic test_payload();
        bit to;
        sums_t s;
        s = '0;
        s[0] = 32'h01020304;
        s[7] = 32'hDEADBEEF;
        iErrorSums = s;
        build_expected(s);
        clear_mon();
        pulse_done();
        iErrorSums = {NUM_OUTPUTS{32'hFFFF_FFFF}};
        wait_ack(200, 1'b0, to);
        checks++;
        if (to || rx.size() != FRAME_LEN) begin errors++; $display("[TB] FAIL payload_len got %0d want %0d", rx.size(), FRAME_LEN); end
        for (int i = 0; i < FRAME_LEN && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL payload_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
        end
        if (rx.size() >= 33) begin
            checks++;
            if ({rx[1], rx[2], rx[3], rx[4]} !== 32'h01020304) begin
                errors++; $display("[TB] FAIL payload_sum0 got %h%h%h%h want 01020304", rx[1], rx[2], rx[3], rx[4]);
            end
            checks++;
            if ({rx[29], rx[30], rx[31], rx[32]} !== 32'hDEADBEEF) begin
                errors++; $display("[TB] FAIL payload_sum7 got %h%h%h%h want deadbeef", rx[29], rx[30], rx[31], rx[32]);
            end
        end
`ifdef ERROR_SUM_TX_CHECKSUM_EN
        if (rx.size() >= 34) begin
            checks++;
            if (rx[33] !== 8'h26) begin errors++; $display("[TB] FAIL checksum got %h want 26", rx[33]); end
        end
        if (acks.size() > 0) begin
            checks++;
            if (acks[0] != n_cyc + 36) begin errors++; $display("[TB] FAIL checksum_ack_latency got %0d want 36", acks[0] - n_cyc); end
        end
`endif
    endtask

    task automatic test_stall();
        bit to;
        sums_t s;
        for (int i = 0; i < NUM_OUTPUTS; i++) s[i] = 32'h10203040 + 32'(i) * 32'h01010101;
        iErrorSums = s;
        build_expected(s);
        clear_mon();
        iTxReady = 1'b0;
        pulse_done();
        wait_ack(2000, 1'b1, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL stall_ack_timeout got timeout want ack"); end
        checks++;
        if (stall_err != 0) begin errors++; $display("[TB] FAIL stall_hold got %0d violations want 0", stall_err); end
        checks++;
        if (rx.size() != FRAME_LEN) begin errors++; $display("[TB] FAIL stall_len got %0d want %0d", rx.size(), FRAME_LEN); end
        for (int i = 0; i < FRAME_LEN && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL stall_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
        end
        checks++;
        if (acks.size() != 1 || acks[0] <= last_xfer_cyc) begin
            errors++; $display("[TB] FAIL stall_ack_order got %0d acks want 1 after cycle %0d", acks.size(), last_xfer_cyc);
        end
    endtask

    task automatic test_held_done();
        bit to;
        int busy_low;
        sums_t s;
        s = '0;
        s[3] = 32'hCAFE0001;
        iErrorSums = s;
        clear_mon();
        iDoneProcessing = 1'b1;
        wait_ack(200, 1'b0, to);
        busy_low = 0;
        repeat (200) begin
            next_cycle();
            if (oBusy !== 1'b1) busy_low++;
        end
        checks++;
        if (to || acks.size() != 1) begin errors++; $display("[TB] FAIL held_ack_count got %0d want 1", acks.size()); end
        checks++;
        if (rx.size() != FRAME_LEN) begin errors++; $display("[TB] FAIL held_single_frame got %0d bytes want %0d", rx.size(), FRAME_LEN); end
        checks++;
        if (busy_low != 0) begin errors++; $display("[TB] FAIL held_busy got %0d low cycles want 0", busy_low); end
        iDoneProcessing = 1'b0;
        repeat (2) next_cycle();
        checks++;
        if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL held_release got busy %b want 0", oBusy); end
        clear_mon();
        pulse_done();
        wait_ack(200, 1'b0, to);
        checks++;
        if (to || rx.size() != FRAME_LEN || acks.size() != 1) begin
            errors++; $display("[TB] FAIL held_second_frame got %0d bytes %0d acks want %0d and 1", rx.size(), acks.size(), FRAME_LEN);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int guard;
        sums_t s;
        s = '0;
        s[1] = 32'h55AA55AA;
        iErrorSums = s;
        build_expected(s);
        clear_mon();
        pulse_done();
        guard = 0;
        while (rx.size() < 10 && guard < 100) begin
            next_cycle();
            guard++;
        end
        checks++;
        if (rx.size() < 10) begin errors++; $display("[TB] FAIL mid_reach_byte10 got %0d bytes want 10", rx.size()); end
        #2;
        iReset_n = 1'b0;
        #1;
        checks++;
        if (oTxValid !== 1'b0 || oTxByte !== 8'h00 || oBusy !== 1'b0 || oDoneProcessingFeedback !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_reset_outputs got v%b b%h busy%b ack%b want all 0",
                               oTxValid, oTxByte, oBusy, oDoneProcessingFeedback);
        end
        repeat (5) next_cycle();
        iReset_n = 1'b1;
        repeat (5) next_cycle();
        checks++;
        if (acks.size() != 0) begin errors++; $display("[TB] FAIL mid_no_ack got %0d acks want 0", acks.size()); end
        clear_mon();
        pulse_done();
        wait_ack(200, 1'b0, to);
        checks++;
        if (to || rx.size() != FRAME_LEN || acks.size() != 1) begin
            errors++; $display("[TB] FAIL mid_new_frame got %0d bytes %0d acks want %0d and 1", rx.size(), acks.size(), FRAME_LEN);
        end
        for (int i = 0; i < FRAME_LEN && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL mid_byte%0d got %h want %h", i, rx[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_payload();
        test_stall();
        test_held_done();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout got timeout want finish");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
